// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encodings and widths for the debouncer
// Purpose: FSM state type and glitch counter width used by debounce_sync.
// Ports: none (package).
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b11,
    CHK_LO  = 2'b10
  } state_t;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous level
// Purpose: brings an async input into the clk domain; both flops reset to 0.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   d   - asynchronous input level
//   q   - synchronised level (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // s1 feeds q directly so the metastability settling window is a full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronising debouncer with rise/fall strobes
// Purpose: synchronises din, then only lets dout follow after the synchronised
//   level has been stable for STABLE_CYCLES consecutive cycles.
// Optional: define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt port.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   din        - raw asynchronous level (button/switch)
//   dout       - debounced synchronised level
//   rise       - one-cycle strobe when dout goes 0->1
//   fall       - one-cycle strobe when dout goes 1->0
//   busy       - high while a candidate transition is being qualified
//   glitch_cnt - count of aborted qualifications, saturating (optional)
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             din_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  // Entering CHK_* already counts the first stable sample (cnt=1), so the
  // final qualifying sample is the one seen while cnt==STABLE_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (din_s) begin
            state <= CHK_HI;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        CHK_HI: begin
          if (!din_s) begin
            state <= IDLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HI;
            cnt   <= '0;
            dout  <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!din_s) begin
            state <= CHK_LO;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        CHK_LO: begin
          if (din_s) begin
            state <= IDLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // A reversal while qualifying is a bounce that never reached dout.
  logic abort;
  assign abort = ((state == CHK_HI) && !din_s) || ((state == CHK_LO) && din_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync
module tb_debounce_sync;

  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  always #10 clk = ~clk;

  debounce_sync #(.STABLE_CYCLES(SC)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  typedef struct {
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: din is seen by the filter two edges late; dout flips once the
  // run of consecutive samples differing from dout reaches SC.
  logic m_s1, m_s2, m_dout, m_rise, m_fall, m_busy;
  int   run;
  int   m_glitch;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    m_busy = 1'b0; run = 0; m_glitch = 0;
  endtask

  task automatic model_edge();
    logic samp;
    samp   = m_s2;
    m_s2   = m_s1;
    m_s1   = din;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (samp != m_dout) begin
      run++;
      if (run == SC) begin
        m_dout = samp;
        run    = 0;
        if (samp) m_rise = 1'b1;
        else      m_fall = 1'b1;
      end
    end else begin
      if (run > 0 && m_glitch < 255) m_glitch++;
      run = 0;
    end
    m_busy = (run > 0);
  endtask

  task automatic chk_model();
    chk("mdl_dout", {7'd0, dout}, {7'd0, m_dout});
    chk("mdl_rise", {7'd0, rise}, {7'd0, m_rise});
    chk("mdl_fall", {7'd0, fall}, {7'd0, m_fall});
    chk("mdl_busy", {7'd0, busy}, {7'd0, m_busy});
    chk("mdl_excl", {7'd0, rise & fall}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("mdl_glitch", glitch_cnt, 8'(m_glitch));
`endif
  endtask

  // Drive din, take one rising edge, settle to the falling edge and compare.
  task automatic step(input logic d, input bit cm);
    din = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (cm) chk_model();
  endtask

  // Called at a falling edge; asserts rst off the clock edge, checks the
  // held-reset outputs, releases at a later falling edge.
  task automatic apply_reset(input logic d);
    din = d;
    #3 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_dout", {7'd0, dout}, 8'd0);
      chk("rst_rise", {7'd0, rise}, 8'd0);
      chk("rst_fall", {7'd0, fall}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      @(negedge clk);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("rst_glitch", glitch_cnt, 8'd0);
`endif
    rst = 1'b0;
  endtask

  vec_t tbl[24];

  initial begin
    logic v;
    int   len;

    // Clean rise then clean fall; index = edge number from the din change.
    for (int i = 0; i < 24; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    din = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with din=1, then full qualification after release.
    apply_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      if (i == 8) chk("rel_dout_e8", {7'd0, dout}, 8'd0);
      if (i == 9) chk("rel_dout_e9", {7'd0, dout}, 8'd1);
      if (i == 9) chk("rel_rise_e9", {7'd0, rise}, 8'd1);
      if (i == 10) chk("rel_rise_e10", {7'd0, rise}, 8'd0);
    end

    // Table: clean step up and back down.
    apply_reset(1'b0);
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].din, 1'b1);
      chk($sformatf("tbl%0d_dout", i), {7'd0, dout}, {7'd0, tbl[i].dout});
      chk($sformatf("tbl%0d_rise", i), {7'd0, rise}, {7'd0, tbl[i].rise});
      chk($sformatf("tbl%0d_fall", i), {7'd0, fall}, {7'd0, tbl[i].fall});
      chk($sformatf("tbl%0d_busy", i), {7'd0, busy}, {7'd0, tbl[i].busy});
    end

    // Bounce 1,1,0,0,1,1,0,0 then hold 1.
    apply_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      step((i % 4) < 2, 1'b1);
      chk("bnc_dout", {7'd0, dout}, 8'd0);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      if (i == 8) chk("bnc_dout_e8", {7'd0, dout}, 8'd0);
      if (i == 9) chk("bnc_dout_e9", {7'd0, dout}, 8'd1);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("bnc_glitch", glitch_cnt, 8'd2);
`endif

    // Short pulse of 5 cycles never reaches dout.
    apply_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      step(i < 5, 1'b1);
      chk("sp_dout", {7'd0, dout}, 8'd0);
      chk("sp_rise", {7'd0, rise}, 8'd0);
    end
    chk("sp_busy_end", {7'd0, busy}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("sp_glitch", glitch_cnt, 8'd1);
`endif

    // Reset mid-qualification (cnt=5 after edge 6), asynchronous to clk.
    apply_reset(1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    chk("mq_busy_pre", {7'd0, busy}, 8'd1);
    #4 rst = 1'b1;
    #1;
    chk("mq_busy_rst", {7'd0, busy}, 8'd0);
    chk("mq_dout_rst", {7'd0, dout}, 8'd0);
    model_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      if (i == 8) chk("mq_dout_e8", {7'd0, dout}, 8'd0);
      if (i == 9) chk("mq_dout_e9", {7'd0, dout}, 8'd1);
      if (i == 9) chk("mq_rise_e9", {7'd0, rise}, 8'd1);
    end

    // Randomised runs of varying length against the reference model.
    apply_reset(1'b0);
    for (int r = 0; r < 300; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) step(v, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Upstream conditioning stage for the D flip-flop stage.
- Takes a raw, asynchronous, possibly bouncing level input and synchronises it into the clk domain.
- Filters bounce: the output changes only after the input has been stable for a programmable number of cycles.
- Drives a clean level on dout (wired to the flop's D input), plus single-cycle rise/fall strobes for downstream logic.

Parameters:
- STABLE_CYCLES, 8, consecutive synchronised-stable cycles required before dout changes; legal range 2..255.
- CNT_W, $clog2(STABLE_CYCLES)+1, stability counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  raw asynchronous level, e.g. a button or switch.
- dout  output  1  debounced, synchronised level; feeds downstream D.
- rise  output  1  one-cycle pulse in the cycle dout goes 0->1.
- fall  output  1  one-cycle pulse in the cycle dout goes 1->0.
- busy  output  1  high while in a CHK_* state, i.e. a candidate transition is being qualified.
- glitch_cnt  output  8  present only with DEBOUNCE_GLITCH_CNT_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, rst=1), all held while rst high:
  - sync flops s1=s2=0, FSM=IDLE_LO, cnt=0.
  - dout=0, rise=0, fall=0, busy=0.
- Synchroniser: two flops in series, din->s1->s2. din_s=s2. No logic between s1 and s2.
- FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO. All outputs registered.
- IDLE_LO:
  - din_s=1 -> CHK_HI, cnt=1.
  - otherwise stay.
- CHK_HI:
  - din_s=0 -> IDLE_LO, cnt=0 (glitch aborted).
  - din_s=1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, dout=1, rise=1 for exactly that cycle, cnt=0.
  - otherwise cnt=cnt+1.
- IDLE_HI and CHK_LO: mirror images of the above, with fall instead of rise.
- busy=1 exactly when the next-state register is CHK_HI or CHK_LO.
- Latency: a clean din step set up before rising edge 0 updates dout/rise on edge STABLE_CYCLES+1. With the default 8, dout changes after the 10th edge (edge 9).
- Bounce:
  - Any reversal of din_s during CHK_* restarts qualification from the IDLE state.
  - No partial credit: the counter is not retained across reversals.
- Pulses shorter than STABLE_CYCLES synchronised cycles never reach dout.
- rise and fall are never both high. Each is high for exactly one cycle per dout edge.
- Reset asserted mid-CHK_* aborts immediately, asynchronously, to IDLE_LO with dout=0. After deassertion, din=1 must re-qualify fully (STABLE_CYCLES+2 edges).
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Port glitch_cnt[7:0] exists.
  - Increments by 1 on each CHK_HI->IDLE_LO or CHK_LO->IDLE_HI abort.
  - Saturates at 255. Reset value 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package/include debounce_pkg holds:
  - 2-bit state encodings: IDLE_LO=2'b00, CHK_HI=2'b01, IDLE_HI=2'b11, CHK_LO=2'b10.
  - GLITCH_W=8.
- One sub-module: sync_2ff (clk, rst, d, q), the two-flop synchroniser, reset to 0. Reused for other async inputs.

Test Plan (all with STABLE_CYCLES=8, clk period 20 ns):
- Reset: rst=1 with din=1 -> dout=0, rise=fall=busy=0 throughout. After release, dout=1 at the 10th edge, with rise high for that one cycle only.
- Clean step: din 0->1 before edge 0 -> busy=1 from edge 2; dout=1 and rise=1 after edge 9; rise=0 after edge 10.
- Bounce: din toggles 1,0,1,0 every 2 cycles, then holds 1 -> dout stays 0 during the bounce; dout=1 exactly 10 edges after the final stable 1. With the macro, glitch_cnt equals the number of aborts.
- Short pulse: din=1 for 5 cycles, then 0 -> dout never leaves 0, rise never asserts, busy returns to 0; glitch_cnt=1 when the macro is defined.
- Falling edge: starting from dout=1, din 1->0 -> dout=0 and fall=1 for one cycle at edge 9; rise stays 0.
- Reset mid-qualification: rst pulsed asynchronously (not aligned to clk) during CHK_HI at cnt=5 -> dout=0, busy=0 immediately. With din still 1, dout rises 10 edges after rst deasserts.
